// File: rtl/xalu_nibble_seq.sv
// Word-wide sequencer for a 4-bit ALU slice: runs one nibble per cycle,
// chains carries/shift bits between nibbles and accumulates status flags.
module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic                 com,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 zero,
  output logic                 neg_zero,
  output logic                 equ,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_f,
  output logic                 alu_com,
  output logic                 alu_ci_left,
  output logic                 alu_ci_right,
  input  logic [3:0]           alu_d,
  input  logic                 alu_co_left,
  input  logic                 alu_co_right,
  input  logic                 alu_zero,
  input  logic                 alu_neg_zero,
  input  logic                 alu_equ
);

  localparam int         W    = 4 * NIBBLES;
  localparam logic [3:0] LAST = 4'(NIBBLES - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_q, b_q, shadow;
  logic [2:0]     op_q;
  logic           com_q;
  logic           carry_q;
  logic [3:0]     k;
  logic           zero_acc, neg_zero_acc, equ_acc;

  logic           run, is_shr;
  logic [3:0]     idx;
  logic [5:0]     sh;
  logic [W-1:0]   a_sh, b_sh, shadow_nxt;

  always_comb begin
    run        = (state == S_RUN);
    is_shr     = (op_q == OP_SHR);
    idx        = is_shr ? (LAST - k) : k;
    sh         = {idx, 2'b00};
    a_sh       = a_q >> sh;
    b_sh       = b_q >> sh;
    shadow_nxt = (shadow & ~({{(W-4){1'b0}}, 4'hF} << sh))
               | ({{(W-4){1'b0}}, alu_d} << sh);

    alu_a        = run ? a_sh[3:0] : '0;
    alu_b        = run ? b_sh[3:0] : '0;
    alu_f        = run ? op_q : '0;
    alu_com      = run & com_q;
    // carry_q is seeded with cin at start, so it serves as both the k=0
    // carry-in and the registered chain carry for later nibbles.
    alu_ci_right = run & ~is_shr & carry_q;
    alu_ci_left  = run &  is_shr & carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      shadow       <= '0;
      op_q         <= '0;
      com_q        <= 1'b0;
      carry_q      <= 1'b0;
      k            <= '0;
      zero_acc     <= 1'b0;
      neg_zero_acc <= 1'b0;
      equ_acc      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      cout         <= 1'b0;
      zero         <= 1'b0;
      neg_zero     <= 1'b0;
      equ          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q          <= a;
            b_q          <= b;
            op_q         <= op;
            com_q        <= com;
            carry_q      <= cin;
            k            <= '0;
            shadow       <= '0;
            zero_acc     <= 1'b1;
            neg_zero_acc <= 1'b1;
            equ_acc      <= 1'b1;
            busy         <= 1'b1;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          shadow       <= shadow_nxt;
          carry_q      <= is_shr ? alu_co_right : alu_co_left;
          zero_acc     <= zero_acc & alu_zero;
          neg_zero_acc <= neg_zero_acc & alu_neg_zero;
          equ_acc      <= equ_acc & alu_equ;
          k            <= k + 4'd1;
          if (k == LAST) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= shadow_nxt;
            zero     <= zero_acc & alu_zero;
            neg_zero <= neg_zero_acc & alu_neg_zero;
            equ      <= equ_acc & alu_equ;
            if (op_q == OP_ADD || op_q == OP_SHL) cout <= alu_co_left;
            else if (is_shr)                      cout <= alu_co_right;
            else                                  cout <= 1'b0;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
